gray_to_rgb565_ise: RTL
=======================

Name: gray_to_rgb565_ise

Overview:
- Custom-instruction block: expands four 8-bit grayscale bytes into four RGB565 pixels, byte-swapped to match the camera/display pixel layout. It is the inverse path of the RGB565-to-grayscale instruction.
- The 32-bit result bus holds only two pixels, so the block is a small FSM:
  - CONVERT returns pixels 0/1 and buffers pixels 2/3.
  - FETCH returns the buffered pair.
- Sits on the CPU custom-instruction port, alongside the other ISEs.

Parameters:
customInstructionId, 8'd14, iseId value this block responds to.

Ports:
clock   in   1   system clock, rising edge
nReset  in   1   asynchronous active-low reset
start   in   1   instruction-start strobe (one cycle)
iseId   in   8   custom-instruction number
valueA  in   32  CONVERT: gray bytes, pixel0=[7:0] .. pixel3=[31:24]; ignored on FETCH
valueB  in   32  [0]=0 CONVERT, [0]=1 FETCH; [31:1] ignored
done    out  1   one-cycle completion pulse
result  out  32  {pixel_hi[15:0], pixel_lo[15:0]} while done=1, else 0

Behaviour:
- Accept condition: start & (iseId==customInstructionId) & state==IDLE. Any other start (wrong id, or FSM busy) is ignored: no done pulse, no state change.
- States:
  - IDLE
  - EXPAND: gray register holds valueA.
  - RESP: done=1; result register is valid.
- Transitions:
  - IDLE -> EXPAND on accepted CONVERT.
  - IDLE -> RESP on accepted FETCH.
  - EXPAND -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- Latency, counted from the accepting edge t:
  - CONVERT: done high in cycle t+2.
  - FETCH: done high in cycle t+1.
  - A start in the RESP cycle is ignored. The next accept is possible one cycle later.
- CONVERT, on the EXPAND->RESP edge:
  - result <= {px(g1), px(g0)}.
  - Buffer <= {px(g3), px(g2)}, bufValid <= 1. A new CONVERT overwrites an unfetched buffer.
- FETCH:
  - result <= bufValid ? buffer : 32'h0.
  - bufValid <= 0, so a second FETCH returns 0.
- Pixel expansion px(g):
  - r5 = g[7:3], g6 = g[7:2], b5 = g[7:3].
  - Packing: px[15:13]=g6[2:0], px[12:8]=b5, px[7:3]=r5, px[2:0]=g6[5:3].
- done and result are registered outputs; result is forced to 0 outside RESP.
- Reset (nReset low, asynchronous, including mid-operation):
  - state=IDLE, done=0, result=0, bufValid=0, buffer=0, gray register=0.
  - No pending instruction completes after reset is released.

Optional Feature:
- Macro: GRAY2RGB_ROUND_EN.
- Defined: round-to-nearest with saturation.
  - r5 = b5 = min(31, (g+4)>>3), computed 9 bits wide.
  - g6 = min(63, (g+2)>>2).
- Undefined: plain truncation as in Behaviour.
- Timing, FSM and packing are identical in both builds.

Decomposition:
- Shared package gray2rgb_pkg holds:
  - Op-select constants OP_CONVERT=1'b0, OP_FETCH=1'b1.
  - FSM state enum {IDLE, EXPAND, RESP}.
  - 16-bit pixel typedef.
  - Packing bit-position constants, shared with the forward grayscale ISE.
- One natural sub-module, gray_to_rgb565_pixel:
  - Combinational 8->16-bit expansion, including the GRAY2RGB_ROUND_EN branch.
  - Instantiated four times.
- The FSM and buffer stay in the top level.

Test Plan:
- Non-matching or idle: start=1, iseId=47, any operands -> done=0, result=0 for 3 cycles; a subsequent FETCH returns 0 (bufValid still 0).
- CONVERT: valueA=32'hFFC08040, valueB=0 -> done in cycle t+2, result=32'h10840842. Then FETCH (valueB=1) -> done in cycle t+1, result=32'hFFFF18C6. A second FETCH -> result=0.
- Extremes: CONVERT valueA=32'hFFFFFFFF -> result=32'hFFFFFFFF. CONVERT valueA=0 -> result=0 with done=1.
- Busy and overwrite:
  - A second start during EXPAND is ignored: exactly one done pulse.
  - CONVERT 32'hFFC08040, then CONVERT 32'h0, then FETCH -> 0.
- Reset mid-operation: assert nReset during EXPAND -> done never pulses; outputs 0; FETCH after release returns 0.
- Rounding, gray byte 0x7E in pixel0:
  - Without the macro -> result[15:0]=16'hEF7B.
  - With GRAY2RGB_ROUND_EN -> 16'h1084.
  - Gray byte 0xFE -> 16'hFFFF in both builds (saturation).

Source files
------------

// File: rtl/gray2rgb_pkg.sv
// Shared definitions for the gray -> RGB565 custom instruction: op select, FSM states,
// pixel type and the byte-swapped RGB565 bit positions used by the grayscale ISE pair.
package gray2rgb_pkg;

   localparam logic OP_CONVERT = 1'b0;
   localparam logic OP_FETCH   = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef logic [15:0] pixel_t;

   // Byte-swapped RGB565: low green bits sit on top, high green bits at the bottom.
   localparam int PX_G_LO_MSB = 15;
   localparam int PX_G_LO_LSB = 13;
   localparam int PX_B_MSB    = 12;
   localparam int PX_B_LSB    = 8;
   localparam int PX_R_MSB    = 7;
   localparam int PX_R_LSB    = 3;
   localparam int PX_G_HI_MSB = 2;
   localparam int PX_G_HI_LSB = 0;

endpackage

// File: rtl/gray_to_rgb565_pixel.sv
// Combinational expansion of one gray byte into a byte-swapped RGB565 pixel.
// Build option GRAY2RGB_ROUND_EN selects round-to-nearest with saturation instead of truncation.
module gray_to_rgb565_pixel
   import gray2rgb_pkg::*;
(
   input  logic [7:0]  gray,
   output logic [15:0] pixel
);

   logic [4:0] rb5;
   logic [5:0] g6;

`ifdef GRAY2RGB_ROUND_EN
   logic [5:0] rb_wide;
   logic [6:0] g_wide;

   // Sums are 9 bits wide so 0xFC..0xFF can carry past 255 and then saturate.
   assign rb_wide = 6'(({1'b0, gray} + 9'd4) >> 3);
   assign g_wide  = 7'(({1'b0, gray} + 9'd2) >> 2);
   assign rb5     = rb_wide[5] ? 5'd31 : rb_wide[4:0];
   assign g6      = g_wide[6]  ? 6'd63 : g_wide[5:0];
`else
   assign rb5 = 5'(gray >> 3);
   assign g6  = 6'(gray >> 2);
`endif

   always_comb begin
      pixel = '0;
      pixel[PX_G_LO_MSB:PX_G_LO_LSB] = g6[2:0];
      pixel[PX_B_MSB:PX_B_LSB]       = rb5;
      pixel[PX_R_MSB:PX_R_LSB]       = rb5;
      pixel[PX_G_HI_MSB:PX_G_HI_LSB] = g6[5:3];
   end

endmodule

// File: rtl/gray_to_rgb565_ise.sv
// Custom instruction: expands four gray bytes into four RGB565 pixels; CONVERT returns pixels 0/1
// and buffers 2/3, FETCH returns the buffered pair. Rounding build option: GRAY2RGB_ROUND_EN.
module gray_to_rgb565_ise
   import gray2rgb_pkg::*;
#(
   parameter logic [7:0] customInstructionId = 8'd14
)(
   input  logic        clock,
   input  logic        nReset,
   input  logic        start,
   input  logic [7:0]  iseId,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result,
   output logic [1:0]  state_dbg
);

   // Handshake: start is a one-cycle strobe, accepted only in IDLE with a matching iseId;
   // done is a one-cycle pulse and result is valid only while done is high (0 otherwise).

   state_t      state, next_state;
   logic [31:0] gray_q;
   logic [31:0] buffer_q;
   logic        buf_valid_q;
   logic        accept;
   pixel_t      px [4];

   wire unused_value_b = ^valueB[31:1];

   assign accept    = start && (iseId == customInstructionId) && (state == IDLE);
   assign state_dbg = state;

   for (genvar i = 0; i < 4; i++) begin : g_px
      gray_to_rgb565_pixel u_pixel (
         .gray  (gray_q[8*i +: 8]),
         .pixel (px[i])
      );
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = (valueB[0] == OP_FETCH) ? RESP : EXPAND;
         EXPAND:  next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state       <= IDLE;
         done        <= 1'b0;
         result      <= '0;
         gray_q      <= '0;
         buffer_q    <= '0;
         buf_valid_q <= 1'b0;
      end else begin
         state  <= next_state;
         done   <= 1'b0;
         result <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (valueB[0] == OP_FETCH) begin
                     done        <= 1'b1;
                     result      <= buf_valid_q ? buffer_q : 32'h0;
                     buf_valid_q <= 1'b0;
                  end else begin
                     gray_q <= valueA;
                  end
               end
            end
            EXPAND: begin
               done        <= 1'b1;
               result      <= {px[1], px[0]};
               buffer_q    <= {px[3], px[2]};
               buf_valid_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
